// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-PC sequencer.
package pc_sequencer_pkg;

  typedef logic [31:0] addr_t;

  // S_SEQ: ordinary sequential fetch.
  // S_SLOT: pc is a delay slot; the branch successor waits in delayed_pc.
  typedef enum logic {
    S_SEQ  = 1'b0,
    S_SLOT = 1'b1
  } seq_state_t;

  localparam addr_t RESET_PC_DEFAULT = 32'hbfc0_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Step/redirect inputs and PC/bookkeeping outputs of the sequencer.
// The master drives retirement events; the slave (sequencer) answers with fetch state.
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  import pc_sequencer_pkg::*;

  logic             step_valid;
  logic             step_is_branch;
  logic             step_taken;
  addr_t            step_target;
  logic             redirect_valid;
  addr_t            redirect_pc;

  addr_t            pc;
  logic             in_slot;
  addr_t            cur_epc;
  logic             cur_bd;
  logic             slot_branch_err;
  logic [CNT_W-1:0] retired;

  modport master (
    output step_valid, step_is_branch, step_taken, step_target,
           redirect_valid, redirect_pc,
    input  pc, in_slot, cur_epc, cur_bd, slot_branch_err, retired
  );

  modport slave (
    input  step_valid, step_is_branch, step_taken, step_target,
           redirect_valid, redirect_pc,
    output pc, in_slot, cur_epc, cur_bd, slot_branch_err, retired
  );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: sequential advance, branch delay slot, redirects,
// exception EPC/BD and a retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  seq_state_t       state_q, state_d;
  addr_t            pc_q, pc_d;
  addr_t            delayed_pc_q, delayed_pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Next-state: redirect beats step; a branch is credited when its slot retires.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    delayed_pc_d = delayed_pc_q;
    err_d        = 1'b0;
    retired_d    = retired_q;
    if (bus.redirect_valid) begin
      // The faulting/returning instruction does not retire.
      pc_d         = bus.redirect_pc;
      state_d      = S_SEQ;
      delayed_pc_d = '0;
    end else if (bus.step_valid) begin
      case (state_q)
        S_SEQ: begin
          pc_d = pc_q + 32'd4;
          if (bus.step_is_branch) begin
            state_d      = S_SLOT;
            delayed_pc_d = bus.step_taken ? bus.step_target : pc_q + 32'd8;
          end else begin
            retired_d = retired_q + CNT_W'(1);
          end
        end
        S_SLOT: begin
          // A branch in a slot is undefined: run it as a plain instruction and flag it.
          pc_d      = delayed_pc_q;
          state_d   = S_SEQ;
          retired_d = retired_q + CNT_W'(2);
          err_d     = bus.step_is_branch;
        end
        default: state_d = S_SEQ;
      endcase
    end
  end

  // State register with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SEQ;
      pc_q         <= RESET_PC;
      delayed_pc_q <= '0;
      err_q        <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      delayed_pc_q <= delayed_pc_d;
      err_q        <= err_d;
      retired_q    <= retired_d;
    end
  end

  // EPC points back at the branch when the faulting instruction sits in its slot.
  always_comb begin
    bus.pc              = pc_q;
    bus.in_slot         = (state_q == S_SLOT);
    bus.cur_bd          = (state_q == S_SLOT);
    bus.cur_epc         = (state_q == S_SLOT) ? pc_q - 32'd4 : pc_q;
    bus.slot_branch_err = err_q;
    bus.retired         = retired_q;
  end

endmodule
